alu_op_issue: RTL and testbench

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

---
 rtl/alu_op_issue.sv | 145 ++++++++++++++
 tb/tb_alu_op_issue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// Decodes RV32I ALU-class instructions into ALU operands and an operation code.
// The decoded result is held in a 2-entry in-order issue buffer.
module alu_op_issue #(
  parameter int REG_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic [REG_WIDTH-1:0] rs1_data,
  input  logic [REG_WIDTH-1:0] rs2_data,
  input  logic [REG_WIDTH-1:0] imm,
  input  logic [REG_WIDTH-1:0] pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  output logic [3:0]           alu_op,
  output logic                 illegal
);

  localparam logic [3:0] OP_OR   = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1101;

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [REG_WIDTH-1:0] a;
    logic [REG_WIDTH-1:0] b;
    logic [3:0]           op;
    logic                 ill;
  } entry_t;

  entry_t     dec;
  entry_t     head;
  entry_t     tail;
  logic [1:0] count;
  logic       push;
  logic       pop;

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? OP_SUB : OP_ADD;
      3'b001:  arith_op = OP_SLL;
      3'b010:  arith_op = OP_SLT;
      3'b011:  arith_op = OP_SLTU;
      3'b100:  arith_op = OP_XOR;
      3'b101:  arith_op = alt ? OP_SRA : OP_SRL;
      3'b110:  arith_op = OP_OR;
      default: arith_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    dec.a   = '0;
    dec.b   = '0;
    dec.op  = OP_ADD;
    dec.ill = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.a  = rs1_data;
        dec.b  = rs2_data;
        dec.op = arith_op(funct3, funct7_5);
      end
      7'b0010011: begin
        // immediate forms have no SUB; bit 30 only selects SRA
        dec.a  = rs1_data;
        dec.b  = imm;
        dec.op = arith_op(funct3, funct7_5 && (funct3 == 3'b101));
      end
      7'b0000011, 7'b0100011: begin
        dec.a = rs1_data;
        dec.b = imm;
      end
      7'b0110111: dec.b = imm;
      7'b0010111: begin
        dec.a = pc;
        dec.b = imm;
      end
      7'b1101111, 7'b1100111: begin
        dec.a = pc;
        dec.b = REG_WIDTH'(4);
      end
      7'b1100011: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        case (funct3[2:1])
          2'b00:   dec.op = OP_SUB;
          2'b10:   dec.op = OP_SLT;
          2'b11:   dec.op = OP_SLTU;
          default: dec.ill = 1'b1;
        endcase
      end
      default: dec.ill = 1'b1;
    endcase
  end

  assign in_ready  = (count < FULL);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= 2'd0;
    end else if (push && !pop) begin
      count <= count + 2'd1;
    end else if (pop && !push) begin
      count <= count - 2'd1;
    end
  end

  // push and pop together only happens at count=1, so the new entry goes straight to head
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (push && (count == 2'd0 || pop)) begin
        head <= dec;
      end else if (pop) begin
        head <= tail;
      end
      if (push && (count == 2'd1) && !pop) begin
        tail <= dec;
      end
    end
  end

  assign alu_a   = out_valid ? head.a   : '0;
  assign alu_b   = out_valid ? head.b   : '0;
  assign alu_op  = out_valid ? head.op  : 4'b0000;
  assign illegal = out_valid ? head.ill : 1'b0;

endmodule

// File: tb/tb_alu_op_issue.sv
// Random and directed stimulus for alu_op_issue; a queue-based reference model
// predicts buffer contents and a negedge monitor compares every cycle.
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_data, rs2_data, imm, pc, alu_a, alu_b;
  logic [3:0]  alu_op;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        ill;
  } ent_t;

  ent_t sb[$];

  // funct3-indexed base operation table: AND OR SRL XOR SLTU SLT SLL ADD (msb..lsb)
  localparam logic [31:0] BASE = {4'b0001, 4'b0000, 4'b1010, 4'b1001,
                                  4'b1101, 4'b0101, 4'b1000, 4'b0010};

  alu_op_issue #(.REG_WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic ent_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] im, input logic [31:0] p);
    ent_t e;
    e = '{a: 32'd0, b: 32'd0, op: 4'b0010, ill: 1'b0};
    case (opc)
      7'b0110011: begin
        e.a = r1; e.b = r2; e.op = BASE[f3*4 +: 4];
        if (f7 && (f3 == 3'd0 || f3 == 3'd5)) e.op = e.op + 4'd1;
      end
      7'b0010011: begin
        e.a = r1; e.b = im; e.op = BASE[f3*4 +: 4];
        if (f7 && f3 == 3'd5) e.op = e.op + 4'd1;
      end
      7'b0000011, 7'b0100011: begin e.a = r1; e.b = im; end
      7'b0110111: e.b = im;
      7'b0010111: begin e.a = p; e.b = im; end
      7'b1101111, 7'b1100111: begin e.a = p; e.b = 32'd4; end
      7'b1100011: begin
        e.a = r1; e.b = r2;
        if (f3 < 3'd2) e.op = 4'b0011;
        else if (f3 >= 3'd6) e.op = 4'b1101;
        else e.op = 4'b0101;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // reference model update: flush/reset clear, otherwise pop then accept if room existed
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      armed <= 1'b1;
    end else if (armed) begin
      if (flush) begin
        sb.delete();
      end else if (in_valid && sb.size() < 2) begin
        if (sb.size() > 0 && out_ready) void'(sb.pop_front());
        sb.push_back(ref_dec(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc));
      end else if (sb.size() > 0 && out_ready) begin
        void'(sb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      ent_t exp;
      bit   ev, er;
      ev  = sb.size() > 0;
      er  = sb.size() < 2;
      exp = ev ? sb[0] : '0;
      checks++;
      if (out_valid !== ev || in_ready !== er) begin
        errors++;
        $display("FAIL handshake t=%0t got out_valid=%b in_ready=%b exp out_valid=%b in_ready=%b",
                 $time, out_valid, in_ready, ev, er);
      end
      checks++;
      if ({alu_a, alu_b, alu_op, illegal} !== exp) begin
        errors++;
        $display("FAIL head t=%0t got a=%h b=%h op=%b ill=%b exp a=%h b=%h op=%b ill=%b",
                 $time, alu_a, alu_b, alu_op, illegal, exp.a, exp.b, exp.op, exp.ill);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p, input logic ordy);
    in_valid = 1'b1; opcode = opc; funct3 = f3; funct7_5 = f7;
    rs1_data = r1; rs2_data = r2; imm = im; pc = p; out_ready = ordy;
    step();
  endtask

  task automatic idle(input logic ordy, input int n);
    in_valid = 1'b0; out_ready = ordy;
    repeat (n) step();
  endtask

  function automatic logic [6:0] pick_opc();
    case ($urandom_range(0, 10))
      0, 1:    return 7'b0110011;
      2, 3:    return 7'b0010011;
      4:       return 7'b0000011;
      5:       return 7'b0100011;
      6:       return 7'b0110111;
      7:       return 7'b0010111;
      8:       return ($urandom_range(0, 1) != 0) ? 7'b1101111 : 7'b1100111;
      9:       return 7'b1100011;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
    repeat (2) step();
    reset = 1'b0;
    idle(1'b0, 1);

    // SRA via R-type, AUIPC, BLTU, each with a consuming sink
    offer(7'b0110011, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b1);
    offer(7'b0010111, 3'b000, 1'b0, 32'd7, 32'd9, 32'h2000, 32'h1000, 1'b1);
    offer(7'b1100011, 3'b110, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 1'b1);
    idle(1'b1, 2);

    // three back-to-back pushes into a stalled sink; third must be refused
    offer(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h1, 32'd0, 32'd0, 1'b0);
    offer(7'b0110011, 3'b000, 1'b1, 32'h22, 32'h2, 32'd0, 32'd0, 1'b0);
    offer(7'b0110011, 3'b100, 1'b0, 32'h33, 32'h3, 32'd0, 32'd0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 3);

    // count=1 then simultaneous push and pop
    offer(7'b0010011, 3'b001, 1'b0, 32'h44, 32'd0, 32'd3, 32'd0, 1'b0);
    offer(7'b0010011, 3'b101, 1'b1, 32'h55, 32'd0, 32'd2, 32'd0, 1'b1);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // flush with a full buffer and a same-cycle offer
    offer(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hA000, 32'd0, 1'b0);
    offer(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hB000, 32'd0, 1'b0);
    flush = 1'b1;
    offer(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hC000, 32'd0, 1'b1);
    flush = 1'b0;
    idle(1'b1, 2);

    // unsupported opcode, then reset with a full buffer
    offer(7'b0001111, 3'b010, 1'b1, 32'h77, 32'h88, 32'h99, 32'h100, 1'b1);
    idle(1'b1, 1);
    offer(7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'h400, 1'b0);
    offer(7'b1100111, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'h404, 1'b0);
    reset = 1'b1;
    idle(1'b1, 1);
    reset = 1'b0;
    idle(1'b1, 2);

    for (int i = 0; i < 3000; i++) begin
      logic [6:0] o;
      logic [2:0] f;
      o = pick_opc();
      f = 3'($urandom);
      if (o == 7'b1100011 && f[2:1] == 2'b01) f[2] = 1'b1;
      flush = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      opcode = o; funct3 = f; funct7_5 = 1'($urandom);
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
      step();
    end
    flush = 1'b0; reset = 1'b0;
    idle(1'b1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
